// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register-zero index, ALU opcodes and the ID/EX control bundle.
package cpu_pkg;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_SRA = 4'd9;
    localparam logic [ALUOP_W-1:0] ALU_LUI = 4'd10;
    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic [ALUOP_W-1:0] alu_op;
        logic [REG_AW-1:0]  dest;
    } id_ex_ctrl_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX is still fetching.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dest,
    output logic              load_use
);
    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_dest != REG_ZERO) &
                      ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion, flush and memory-stall hold.
// Defining ID_EX_STALL_COUNT_EN adds a saturating load-use stall counter on perf_stall_cnt.
module id_ex_pipe #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int REG_AW  = cpu_pkg::REG_AW,
    parameter int ALUOP_W = cpu_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               reset,
`ifdef ID_EX_STALL_COUNT_EN
    output logic [31:0]        perf_stall_cnt,
`endif
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_uses_rt,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_reg_dst,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               flush,
    input  logic               mem_stall,
    output logic               stall_id,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_dest,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write
);
    localparam int DW = 4*DATA_W + 2*REG_AW;
    cpu_pkg::id_ex_ctrl_t ctrl_q, ctrl_d, id_ctrl;
    logic [DW-1:0]     dat_q, dat_d;
    logic [REG_AW-1:0] id_dest;
    logic              load_use, capture;

    load_use_detect u_lud (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_valid    (ctrl_q.valid),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_dest     (ctrl_q.dest),
        .load_use    (load_use)
    );

    assign id_dest = id_reg_dst ? id_rd : id_rt;
    // Writes to r0 are dropped here so forwarding never sees a phantom producer.
    always_comb begin
        id_ctrl.valid     = 1'b1;
        id_ctrl.reg_write = id_reg_write & (id_dest != cpu_pkg::REG_ZERO);
        id_ctrl.mem_read  = id_mem_read;
        id_ctrl.mem_write = id_mem_write;
        id_ctrl.alu_op    = id_alu_op;
        id_ctrl.dest      = id_ctrl.reg_write ? id_dest : cpu_pkg::REG_ZERO;
    end

    assign capture  = ~mem_stall & ~flush & ~load_use & id_valid;
    assign stall_id = mem_stall | (load_use & ~flush);
    // Bubbles clear only control; data fields keep their last captured values.
    assign ctrl_d = mem_stall ? ctrl_q : capture ? id_ctrl : '0;
    assign dat_d  = capture ? {id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt} : dat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            dat_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            dat_q  <= dat_d;
        end
    end

    assign {ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt} = dat_q;
    assign ex_valid     = ctrl_q.valid;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_alu_op    = ctrl_q.alu_op;
    assign ex_dest      = ctrl_q.dest;

`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0] cnt_q, cnt_d;
    assign cnt_d = (load_use & ~mem_stall & ~flush & ~&cnt_q) ? cnt_q + 32'd1 : cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign perf_stall_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: scoreboard bench for id_ex_pipe; directed hazard scenarios followed by random traffic.
module tb_id_ex_pipe;
    typedef struct {
        bit v; logic [31:0] pc; logic [4:0] rs, rt, rd; bit ur;
        logic [31:0] rsd, rtd, imm; logic [3:0] op;
        bit rdst, rw, mr, mw, fl, ms;
    } in_t;
    typedef struct {
        bit valid, rw, mr, mw; logic [3:0] op; logic [4:0] dest;
        logic [31:0] pc, rsd, rtd, imm; logic [4:0] rs, rt;
    } st_t;
    typedef struct { bit stall; st_t s; logic [31:0] cnt; } rec_t;

    logic clk = 0, reset = 1;
    in_t cur;
    logic stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm, perf;
    logic [4:0] ex_rs, ex_rt, ex_dest;
    logic [3:0] ex_alu_op;
    rec_t q[$];
    st_t m;
    logic [31:0] m_cnt;
    int checks = 0, fails = 0;
    event pushed;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .reset(reset),
`ifdef ID_EX_STALL_COUNT_EN
        .perf_stall_cnt(perf),
`endif
        .id_valid(cur.v), .id_pc(cur.pc), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .id_uses_rt(cur.ur), .id_rs_data(cur.rsd), .id_rt_data(cur.rtd), .id_imm(cur.imm),
        .id_alu_op(cur.op), .id_reg_dst(cur.rdst), .id_reg_write(cur.rw), .id_mem_read(cur.mr),
        .id_mem_write(cur.mw), .flush(cur.fl), .mem_stall(cur.ms), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );
`ifndef ID_EX_STALL_COUNT_EN
    assign perf = 32'd0;
`endif

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, ex_valid, 0);     chk({tag, "_pc"}, ex_pc, 0);
        chk({tag, "_rsd"}, ex_rs_data, 0);     chk({tag, "_rtd"}, ex_rt_data, 0);
        chk({tag, "_imm"}, ex_imm, 0);         chk({tag, "_rs"}, ex_rs, 0);
        chk({tag, "_rt"}, ex_rt, 0);           chk({tag, "_dest"}, ex_dest, 0);
        chk({tag, "_op"}, ex_alu_op, 0);       chk({tag, "_rw"}, ex_reg_write, 0);
        chk({tag, "_mr"}, ex_mem_read, 0);     chk({tag, "_mw"}, ex_mem_write, 0);
        chk({tag, "_stall"}, stall_id, 0);     chk({tag, "_cnt"}, perf, 0);
    endtask

    function automatic in_t nop();
        in_t x;
        x = '{default: '0};
        return x;
    endfunction

    // Reference: EX stage as a record updated per edge from the hazard/priority rules.
    task automatic step(input in_t x);
        rec_t r;
        bit lu, wr;
        logic [4:0] d;
        @(negedge clk);
        cur = x;
        lu = x.v && m.valid && m.mr && m.dest != 0 && (m.dest == x.rs || (x.ur && m.dest == x.rt));
        r.stall = x.ms || (lu && !x.fl);
        if (!x.ms) begin
            if (lu && !x.fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (x.fl || lu || !x.v) begin
                m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.op = 0; m.dest = 0;
            end else begin
                d = x.rdst ? x.rd : x.rt;
                wr = x.rw && d != 0;
                m = '{valid: 1, rw: wr, mr: x.mr, mw: x.mw, op: x.op, dest: wr ? d : 5'd0,
                      pc: x.pc, rsd: x.rsd, rtd: x.rtd, imm: x.imm, rs: x.rs, rt: x.rt};
            end
        end
        r.s = m;
`ifdef ID_EX_STALL_COUNT_EN
        r.cnt = m_cnt;
`else
        r.cnt = 0;
`endif
        q.push_back(r);
        -> pushed;
    endtask

    initial forever begin
        rec_t e;
        @(pushed);
        #2;
        chk("stall_id", stall_id, q[0].stall);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("ex_valid", ex_valid, e.s.valid);   chk("ex_reg_write", ex_reg_write, e.s.rw);
        chk("ex_mem_read", ex_mem_read, e.s.mr); chk("ex_mem_write", ex_mem_write, e.s.mw);
        chk("ex_alu_op", ex_alu_op, e.s.op);     chk("ex_dest", ex_dest, e.s.dest);
        chk("ex_pc", ex_pc, e.s.pc);             chk("ex_rs_data", ex_rs_data, e.s.rsd);
        chk("ex_rt_data", ex_rt_data, e.s.rtd);  chk("ex_imm", ex_imm, e.s.imm);
        chk("ex_rs", ex_rs, e.s.rs);             chk("ex_rt", ex_rt, e.s.rt);
        chk("perf_cnt", perf, e.cnt);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        in_t x, lw;
        cur = nop();
        m = '{default: '0};
        m_cnt = 0;
        #1 chk_zero("por");
        repeat (2) @(negedge clk);
        reset = 0;
        // Normal capture with R-type destination
        x = nop(); x.v = 1; x.pc = 32'h40; x.rs = 3; x.rsd = 32'h11; x.rt = 4; x.rtd = 32'h22;
        x.rd = 5; x.rdst = 1; x.rw = 1; x.op = 4'd2; x.imm = 32'h7;
        step(x);
        // Load-use on rs: one bubble, then capture
        lw = nop(); lw.v = 1; lw.rs = 1; lw.rt = 8; lw.rw = 1; lw.mr = 1; lw.pc = 32'h44;
        step(lw);
        x = nop(); x.v = 1; x.pc = 32'h48; x.rs = 8; x.rt = 2; x.rd = 9; x.rdst = 1; x.rw = 1;
        x.rsd = 32'hAA; x.rtd = 32'hBB;
        step(x);
        step(x);
        // rt match ignored when rt is not a source
        step(lw);
        x = nop(); x.v = 1; x.rs = 2; x.rt = 8; x.ur = 0; x.rdst = 1; x.rd = 3; x.rw = 1;
        step(x);
        // Load into r0 never stalls
        lw.rt = 0;
        step(lw);
        x = nop(); x.v = 1; x.rs = 0; x.rt = 0; x.ur = 1; x.rdst = 1; x.rd = 6; x.rw = 1;
        step(x);
        // Flush overrides load-use
        lw.rt = 8;
        step(lw);
        x = nop(); x.v = 1; x.rs = 8; x.fl = 1; x.rdst = 1; x.rd = 4; x.rw = 1;
        step(x);
        // Write to r0 is dropped
        x = nop(); x.v = 1; x.rdst = 1; x.rd = 0; x.rw = 1; x.mw = 1; x.pc = 32'h60;
        step(x);
        // mem_stall holds for 3 cycles despite flush, then flush bubbles
        step(lw);
        x = nop(); x.v = 1; x.rs = 8; x.ms = 1; x.fl = 1;
        repeat (3) step(x);
        x.ms = 0;
        step(x);
        // Second counted load-use
        step(lw);
        x = nop(); x.v = 1; x.rs = 7; x.rt = 8; x.ur = 1;
        step(x);
        // Reset asserted mid-cycle while EX holds a valid instruction
        x = nop(); x.v = 1; x.pc = 32'h80; x.rs = 1; x.rt = 2; x.rd = 3; x.rdst = 1; x.rw = 1;
        x.rsd = 32'h5; x.imm = 32'h9;
        step(x);
        @(negedge clk);
        chk("pre_reset_valid", ex_valid, 1);
        cur = nop();
        reset = 1;
        #1 chk_zero("mid_reset");
        m = '{default: '0};
        m_cnt = 0;
        @(negedge clk);
        reset = 0;
        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 400; i++) begin
            x.v = ($urandom % 8) != 0;  x.pc = $urandom;  x.rs = 5'($urandom % 4);
            x.rt = 5'($urandom % 4);    x.rd = 5'($urandom % 4); x.ur = 1'($urandom);
            x.rsd = $urandom; x.rtd = $urandom; x.imm = $urandom; x.op = 4'($urandom);
            x.rdst = 1'($urandom); x.rw = 1'($urandom); x.mr = 1'($urandom); x.mw = 1'($urandom);
            x.fl = ($urandom % 8) == 0; x.ms = ($urandom % 6) == 0;
            step(x);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the 5-stage CPU.
- Captures the two operands delivered combinationally by the register file, plus the decoded immediate and control bits, and presents them to EX one cycle later.
- Contains the load-use hazard detector. On a hazard it stalls IF/ID and inserts a bubble into EX.
- Honours the EX branch flush and the data-memory stall.

Parameters:
DATA_W, 32, operand/PC/immediate width
REG_AW, 5, register index width
ALUOP_W, 4, ALU opcode width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_pc  input  DATA_W  PC of ID instruction
id_rs  input  REG_AW  source register 1 index
id_rt  input  REG_AW  source register 2 index
id_rd  input  REG_AW  R-type destination index
id_uses_rt  input  1  instruction reads rt as a source
id_rs_data  input  DATA_W  register-file read_data1
id_rt_data  input  DATA_W  register-file read_data2
id_imm  input  DATA_W  extended immediate
id_alu_op  input  ALUOP_W  ALU operation
id_reg_dst  input  1  1: dest=rd, 0: dest=rt
id_reg_write  input  1  writes a register
id_mem_read  input  1  load
id_mem_write  input  1  store
flush  input  1  EX branch taken; kill ID instruction
mem_stall  input  1  data memory busy; freeze pipeline
stall_id  output  1  hold PC and IF/ID this cycle
ex_valid  output  1  EX holds a real instruction
ex_pc, ex_rs_data, ex_rt_data, ex_imm  output  DATA_W each  registered copies
ex_rs, ex_rt  output  REG_AW each  registered indices (for forwarding unit)
ex_dest  output  REG_AW  resolved destination
ex_alu_op  output  ALUOP_W  registered ALU op
ex_reg_write, ex_mem_read, ex_mem_write  output  1 each  registered controls

Behaviour:
- Reset (asynchronous, active-high): every ex_* output is 0. stall_id is combinational and therefore 0 while mem_stall=0.
- Destination resolution: dest = id_reg_dst ? id_rd : id_rt. If id_reg_write=0 or dest=0, captured ex_reg_write=0 and ex_dest=0.
- load_use (combinational) = id_valid & ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
- stall_id = mem_stall | (load_use & ~flush).
- Per-edge priority (highest first):
  1. mem_stall=1: all ex_* hold. flush and load_use are ignored this cycle; upstream keeps flush asserted.
  2. flush=1: bubble.
  3. load_use=1: bubble. ID contents are preserved upstream by stall_id.
  4. Otherwise, capture the ID fields. id_valid=0 gives a bubble.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op and ex_dest are cleared to 0. Data and index fields (ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt) retain their previous values.
- Latency: 1 cycle ID→EX. A load-use adds exactly 1 bubble cycle. On the following cycle ex_mem_read=0, so the hazard clears.
- Write-forwarding into the operands is performed inside the register file; this block captures id_rs_data/id_rt_data verbatim.
- Reset mid-stall: outputs clear immediately. After release, the first edge behaves per the priority rules above.

Optional Feature:
- Macro: ID_EX_STALL_COUNT_EN.
- With the macro defined: extra output perf_stall_cnt (32 bits). It increments on each edge where load_use=1, mem_stall=0 and flush=0. It saturates at 32'hFFFFFFFF, and reset clears it to 0.
- Without the macro: the port and its counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - width constants DATA_W, REG_AW, ALUOP_W;
  - REG_ZERO = 5'd0;
  - ALU opcode constants;
  - a packed id_ex_ctrl struct {valid, reg_write, mem_read, mem_write, alu_op, dest}.
- Sub-module load_use_detect: purely combinational. Inputs are the ID indices, id_uses_rt and the EX dest/mem_read/valid; output is load_use. It is reused by the future branch-in-ID hazard logic.

Test Plan:
1. Reset asserted mid-operation with ex_valid=1 → all ex_* read 0 within the same cycle, before any clock edge; stall_id=0.
2. Normal capture: id_pc=0x40, rs=3 (data 0x11), rt=4 (data 0x22), rd=5, reg_dst=1, reg_write=1 → next edge ex_dest=5, ex_rs_data=0x11, ex_rt_data=0x22, ex_valid=1.
3. Load-use: EX holds lw with dest=8; ID reads rs=8 → stall_id=1. Next edge ex_valid=0, ex_dest=0. Following edge the ID instruction is captured with stall_id=0.
4. Load-use masking:
   - EX lw dest=8, ID rt=8 with id_uses_rt=0 → no stall.
   - EX lw dest=0, ID rs=0 → no stall.
5. flush=1 and load_use=1 together → stall_id=0, bubble inserted. Also: id_reg_write=1 with dest=0 → ex_reg_write=0.
6. mem_stall=1 for 3 cycles with flush=1 → ex_* unchanged for all 3 cycles and stall_id=1. First edge after mem_stall drops (flush still 1) → bubble. With ID_EX_STALL_COUNT_EN, two load-use events → perf_stall_cnt=2.
